// File: rtl/hv_stream_sequencer.sv
// rtl/hv_stream_sequencer.sv - HV memory read sequencer feeding a valid/ready stream
// Optional stall counter is built when HV_STREAM_PERF_CNT_EN is defined.
module hv_stream_sequencer #(
  parameter int unsigned DataWidth  = 512,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AddrWidth-1:0]  cfg_start_addr_i,
  input  logic [CountWidth-1:0] cfg_num_entries_i,
  input  logic [CountWidth-1:0] cfg_num_loops_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_en_o,
  output logic [AddrWidth-1:0]  mem_rd_addr_o,
  input  logic [DataWidth-1:0]  mem_rd_data_i,
  output logic [DataWidth-1:0]  stream_data_o,
  output logic [AddrWidth-1:0]  stream_addr_o,
  output logic                  stream_valid_o,
  input  logic                  stream_ready_i,
  output logic [31:0]           stall_cycles_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [AddrWidth-1:0]  r_start_addr;
  logic [AddrWidth-1:0]  r_addr;
  logic [CountWidth-1:0] r_num_entries;
  logic [CountWidth-1:0] r_num_loops;
  logic [CountWidth-1:0] r_entry_idx;
  logic [CountWidth-1:0] r_loop_idx;
  logic                  r_inflight;
  logic [AddrWidth-1:0]  r_inflight_addr;
  logic [DataWidth-1:0]  r_buf_data [2];
  logic [AddrWidth-1:0]  r_buf_addr [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic       w_has_credit;
  logic       w_rd_en;
  logic       w_valid;
  logic       w_pop;
  logic       w_pop_buf;
  logic       w_push;
  logic       w_last_entry;
  logic       w_last_pass;
  logic [1:0] w_count_next;

  // A read may issue only when buffered plus in-flight entries leave a free slot.
  assign w_has_credit = (r_count + {1'b0, r_inflight}) < 2'd2;
  assign w_rd_en      = (r_state == RUN) && !stop_i && w_has_credit;
  assign w_valid      = (r_count != 2'd0) || r_inflight;
  assign w_pop        = w_valid && stream_ready_i;
  assign w_pop_buf    = w_pop && (r_count != 2'd0);
  // Landing data with an empty buffer is presented directly and skips the buffer if taken.
  assign w_push       = r_inflight && !(w_pop && (r_count == 2'd0));
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop_buf};
  assign w_last_entry = (r_entry_idx == r_num_entries - CountWidth'(1));
  assign w_last_pass  = (r_num_loops != '0) && ((r_loop_idx + CountWidth'(1)) == r_num_loops);

  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign mem_rd_en_o    = w_rd_en;
  assign mem_rd_addr_o  = w_rd_en ? r_addr : '0;
  assign stream_valid_o = w_valid;

  always_comb begin
    stream_data_o = '0;
    stream_addr_o = '0;
    if (r_count != 2'd0) begin
      stream_data_o = r_buf_data[r_rd_ptr];
      stream_addr_o = r_buf_addr[r_rd_ptr];
    end else if (r_inflight) begin
      stream_data_o = mem_rd_data_i;
      stream_addr_o = r_inflight_addr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_start_addr  <= '0;
      r_addr        <= '0;
      r_num_entries <= '0;
      r_num_loops   <= '0;
      r_entry_idx   <= '0;
      r_loop_idx    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_start_addr  <= cfg_start_addr_i;
            r_addr        <= cfg_start_addr_i;
            r_num_entries <= cfg_num_entries_i;
            r_num_loops   <= cfg_num_loops_i;
            r_entry_idx   <= '0;
            r_loop_idx    <= '0;
            if (cfg_num_entries_i == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_rd_en) begin
            if (w_last_entry) begin
              r_entry_idx <= '0;
              r_addr      <= r_start_addr;
              r_loop_idx  <= r_loop_idx + CountWidth'(1);
            end else begin
              r_entry_idx <= r_entry_idx + CountWidth'(1);
              r_addr      <= r_addr + AddrWidth'(1);
            end
          end
          if (stop_i || (w_rd_en && w_last_entry && w_last_pass)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_count_next == 2'd0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
      r_buf_data[0]   <= '0;
      r_buf_data[1]   <= '0;
      r_buf_addr[0]   <= '0;
      r_buf_addr[1]   <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_inflight_addr <= r_addr;
      end
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= mem_rd_data_i;
        r_buf_addr[r_wr_ptr] <= r_inflight_addr;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop_buf) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;
    end
  end

`ifdef HV_STREAM_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cycles <= 32'd0;
    end else if ((r_state == IDLE) && start_i) begin
      r_stall_cycles <= 32'd0;
    end else if (w_valid && !stream_ready_i) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cycles;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_hv_stream_sequencer.sv
// tb/tb_hv_stream_sequencer.sv - randomized self-checking bench for hv_stream_sequencer
// Expected streams come from a window/loop address model and a hashed memory image.
module tb_hv_stream_sequencer;
  localparam int DW = 512;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] cfg_start_addr_i = '0;
  logic [CW-1:0] cfg_num_entries_i = '0;
  logic [CW-1:0] cfg_num_loops_i = '0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic [DW-1:0] mem_rd_data_i = '0;
  logic [DW-1:0] stream_data_o;
  logic [AW-1:0] stream_addr_o;
  logic          stream_valid_o;
  logic          stream_ready_i = 1'b0;
  logic [31:0]   stall_cycles_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  hv_stream_sequencer #(.DataWidth(DW), .AddrWidth(AW), .CountWidth(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_start_addr_i(cfg_start_addr_i), .cfg_num_entries_i(cfg_num_entries_i),
    .cfg_num_loops_i(cfg_num_loops_i), .start_i(start_i), .stop_i(stop_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .stream_data_o(stream_data_o), .stream_addr_o(stream_addr_o),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stall_cycles_o(stall_cycles_o)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
    return w;
  endfunction

  // Memory with one cycle of read latency; garbage on idle cycles.
  always @(posedge clk_i) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem_word(mem_rd_addr_o);
    else             mem_rd_data_i <= {16{$urandom()}};
  end

  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic [AW-1:0] exp_q[$];
  int obs_rd, obs_late_rd, obs_done, obs_done_cyc, obs_first_valid, obs_last_hs;
  int obs_credit_viol, obs_stable_viol, obs_stall;
  logic obs_busy_c1, obs_busy_at_done;
  logic [31:0] obs_stall_reg;

  task automatic build_expected(input logic [AW-1:0] sa, input int ne, input int nl);
    exp_q.delete();
    for (int l = 0; l < nl; l++)
      for (int e = 0; e < ne; e++) exp_q.push_back(sa + AW'(e));
  endtask

  function automatic logic [31:0] exp_stall_value();
`ifdef HV_STREAM_PERF_CNT_EN
    return 32'(obs_stall);
`else
    return 32'd0;
`endif
  endfunction

  // Launches one job, drives ready/stop, records what the DUT did; no judgement here.
  task automatic run_job(input logic [AW-1:0] sa, input logic [CW-1:0] ne, input logic [CW-1:0] nl,
                         input int rmode, input int stop_at, input bit poke_start, input int max_cyc);
    int outstanding, post;
    bit stalled;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    obs_addr.delete(); obs_data.delete();
    obs_rd = 0; obs_late_rd = 0; obs_done = 0; obs_done_cyc = -1; obs_first_valid = -1;
    obs_last_hs = -1; obs_credit_viol = 0; obs_stable_viol = 0; obs_stall = 0;
    obs_busy_c1 = 1'b0; obs_busy_at_done = 1'b1;
    outstanding = 0; post = 0; stalled = 1'b0; s_addr = '0; s_data = '0;
    @(negedge clk_i);
    cfg_start_addr_i = sa; cfg_num_entries_i = ne; cfg_num_loops_i = nl;
    start_i = 1'b1; stop_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cfg_start_addr_i = $urandom(); cfg_num_entries_i = CW'($urandom_range(0, 20));
    cfg_num_loops_i = CW'($urandom_range(0, 3));
    for (int c = 1; c <= max_cyc && post < 3; c++) begin
      case (rmode)
        0:       stream_ready_i = 1'b1;
        1:       stream_ready_i = ((c % 3) == 1);
        default: stream_ready_i = 1'($urandom_range(0, 1));
      endcase
      stop_i  = (stop_at > 0) && (c == stop_at);
      start_i = poke_start && (c == 3);
      @(negedge clk_i);
      if (c == 1) obs_busy_c1 = busy_o;
      if (mem_rd_en_o) begin
        obs_rd++;
        if (stop_at > 0 && c >= stop_at) obs_late_rd++;
        if (outstanding >= 2) obs_credit_viol++;
      end
      if (stalled && (!stream_valid_o || stream_addr_o !== s_addr || stream_data_o !== s_data))
        obs_stable_viol++;
      stalled = 1'b0;
      if (stream_valid_o && obs_first_valid < 0) obs_first_valid = c;
      if (stream_valid_o && !stream_ready_i) begin
        obs_stall++; stalled = 1'b1; s_addr = stream_addr_o; s_data = stream_data_o;
      end
      if (stream_valid_o && stream_ready_i) begin
        obs_addr.push_back(stream_addr_o); obs_data.push_back(stream_data_o);
        obs_last_hs = c; outstanding--;
      end
      if (mem_rd_en_o) outstanding++;
      if (done_o) begin
        obs_done++;
        if (obs_done_cyc < 0) begin obs_done_cyc = c; obs_busy_at_done = busy_o; end
      end
      if (obs_done > 0) post++;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0; stop_i = 1'b0;
    obs_stall_reg = stall_cycles_o;
  endtask

  task automatic test_reset;
    @(posedge clk_i); #1;
    total++; if (stream_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", stream_valid_o); end
    total++; if ({busy_o, done_o, mem_rd_en_o} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: busy/done/rd_en got %b want 000", {busy_o, done_o, mem_rd_en_o}); end
    total++; if (stream_data_o !== '0 || stream_addr_o !== '0 || mem_rd_addr_o !== '0) begin bad++; $display("FAIL reset_bus: addr %h data nonzero=%b want 0", stream_addr_o, |stream_data_o); end
    total++; if (stall_cycles_o !== 32'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cycles_o); end
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_basic;
    int n_err;
    run_job(32'h10, 16'd4, 16'd1, 0, 0, 1'b0, 40);
    build_expected(32'h10, 4, 1);
    n_err = 0;
    foreach (obs_addr[i]) if (i >= exp_q.size() || obs_addr[i] !== exp_q[i] || obs_data[i] !== mem_word(exp_q[i])) n_err++;
    total++; if (obs_addr.size() != 4 || n_err != 0) begin bad++; $display("FAIL basic_seq: got %0d entries (%0d wrong) want 4", obs_addr.size(), n_err); end
    total++; if (obs_first_valid != 2) begin bad++; $display("FAIL basic_first_valid: got cycle %0d want 2", obs_first_valid); end
    total++; if (obs_last_hs != 5) begin bad++; $display("FAIL basic_back_to_back: last handshake cycle %0d want 5", obs_last_hs); end
    total++; if (obs_done != 1 || obs_done_cyc <= obs_last_hs) begin bad++; $display("FAIL basic_done: pulses %0d at cycle %0d want 1 after %0d", obs_done, obs_done_cyc, obs_last_hs); end
    total++; if (obs_busy_c1 !== 1'b1 || obs_busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy: at start %b at done %b want 1/0", obs_busy_c1, obs_busy_at_done); end
    total++; if (obs_rd != 4) begin bad++; $display("FAIL basic_reads: got %0d want 4", obs_rd); end
  endtask

  task automatic test_looping;
    int n_err;
    run_job(32'h0, 16'd3, 16'd2, 0, 0, 1'b1, 60);
    build_expected(32'h0, 3, 2);
    n_err = 0;
    foreach (obs_addr[i]) if (i >= exp_q.size() || obs_addr[i] !== exp_q[i] || obs_data[i] !== mem_word(exp_q[i])) n_err++;
    total++; if (obs_addr.size() != 6 || n_err != 0) begin bad++; $display("FAIL loop_seq: got %0d entries (%0d wrong) want 6", obs_addr.size(), n_err); end
    total++; if (obs_done != 1 || obs_rd != 6) begin bad++; $display("FAIL loop_done: done %0d reads %0d want 1/6", obs_done, obs_rd); end
  endtask

  task automatic test_back_pressure;
    int n_err;
    logic [AW-1:0] sa;
    sa = $urandom();
    run_job(sa, 16'd8, 16'd1, 1, 0, 1'b0, 80);
    build_expected(sa, 8, 1);
    n_err = 0;
    foreach (obs_addr[i]) if (i >= exp_q.size() || obs_addr[i] !== exp_q[i] || obs_data[i] !== mem_word(exp_q[i])) n_err++;
    total++; if (obs_addr.size() != 8 || n_err != 0) begin bad++; $display("FAIL bp_seq: got %0d entries (%0d wrong) want 8", obs_addr.size(), n_err); end
    total++; if (obs_stable_viol != 0) begin bad++; $display("FAIL bp_stable: %0d unstable stalled cycles want 0", obs_stable_viol); end
    total++; if (obs_credit_viol != 0) begin bad++; $display("FAIL bp_credit: %0d reads without a free slot want 0", obs_credit_viol); end
    total++; if (obs_stall_reg !== exp_stall_value()) begin bad++; $display("FAIL bp_stall_cnt: got %0d want %0d", obs_stall_reg, exp_stall_value()); end
    total++; if (obs_done != 1) begin bad++; $display("FAIL bp_done: got %0d pulses want 1", obs_done); end
  endtask

  task automatic test_addr_wrap;
    int n_err;
    run_job(32'hFFFF_FFFE, 16'd4, 16'd1, 0, 0, 1'b0, 40);
    build_expected(32'hFFFF_FFFE, 4, 1);
    n_err = 0;
    foreach (obs_addr[i]) if (i >= exp_q.size() || obs_addr[i] !== exp_q[i] || obs_data[i] !== mem_word(exp_q[i])) n_err++;
    total++; if (obs_addr.size() != 4 || n_err != 0) begin bad++; $display("FAIL wrap_seq: got %0d entries (%0d wrong), last addr %h want 4 ending 00000001", obs_addr.size(), n_err, obs_addr.size() > 0 ? obs_addr[obs_addr.size()-1] : 32'h0); end
  endtask

  task automatic test_stop_endless;
    int n_err, ne;
    logic [AW-1:0] sa;
    sa = $urandom(); ne = $urandom_range(3, 6);
    run_job(sa, CW'(ne), 16'd0, 2, 10, 1'b0, 60);
    n_err = 0;
    foreach (obs_addr[i]) if (obs_addr[i] !== sa + AW'(i % ne) || obs_data[i] !== mem_word(sa + AW'(i % ne))) n_err++;
    total++; if (n_err != 0 || obs_addr.size() == 0) begin bad++; $display("FAIL stop_seq: %0d of %0d entries wrong", n_err, obs_addr.size()); end
    total++; if (obs_late_rd != 0) begin bad++; $display("FAIL stop_no_reads: got %0d reads after stop want 0", obs_late_rd); end
    total++; if (obs_addr.size() != obs_rd) begin bad++; $display("FAIL stop_drain: delivered %0d want %0d reads", obs_addr.size(), obs_rd); end
    total++; if (obs_done != 1) begin bad++; $display("FAIL stop_done: got %0d pulses want 1", obs_done); end
  endtask

  task automatic test_zero_len;
    run_job($urandom(), 16'd0, 16'd1, 0, 0, 1'b0, 20);
    total++; if (obs_done_cyc != 1 || obs_done != 1) begin bad++; $display("FAIL zero_done: cycle %0d pulses %0d want 1/1", obs_done_cyc, obs_done); end
    total++; if (obs_rd != 0 || obs_first_valid != -1) begin bad++; $display("FAIL zero_reads: reads %0d first valid %0d want 0/-1", obs_rd, obs_first_valid); end
  endtask

  task automatic test_random;
    int n_err, ne, nl;
    logic [AW-1:0] sa;
    for (int j = 0; j < 6; j++) begin
      sa = $urandom(); ne = $urandom_range(1, 9); nl = $urandom_range(1, 3);
      run_job(sa, CW'(ne), CW'(nl), $urandom_range(0, 2), 0, 1'b0, ne * nl * 6 + 40);
      build_expected(sa, ne, nl);
      n_err = 0;
      foreach (obs_addr[i]) if (i >= exp_q.size() || obs_addr[i] !== exp_q[i] || obs_data[i] !== mem_word(exp_q[i])) n_err++;
      total++; if (obs_addr.size() != exp_q.size() || n_err != 0) begin bad++; $display("FAIL rand%0d_seq: got %0d entries (%0d wrong) want %0d", j, obs_addr.size(), n_err, exp_q.size()); end
      total++; if (obs_done != 1 || obs_rd != ne * nl || obs_credit_viol != 0 || obs_stable_viol != 0) begin bad++; $display("FAIL rand%0d_ctrl: done %0d reads %0d credit %0d stable %0d want 1/%0d/0/0", j, obs_done, obs_rd, obs_credit_viol, obs_stable_viol, ne * nl); end
      total++; if (obs_stall_reg !== exp_stall_value()) begin bad++; $display("FAIL rand%0d_stall: got %0d want %0d", j, obs_stall_reg, exp_stall_value()); end
    end
  endtask

  task automatic test_reset_mid_run;
    int n_err;
    @(negedge clk_i);
    cfg_start_addr_i = 32'h80; cfg_num_entries_i = 16'd8; cfg_num_loops_i = 16'd1;
    start_i = 1'b1; stream_ready_i = 1'b0;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    total++; if (stream_valid_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL midrst_pre: valid %b busy %b want 1/1", stream_valid_o, busy_o); end
    #2 rst_ni = 1'b0;
    #1;
    total++; if ({stream_valid_o, busy_o, done_o, mem_rd_en_o} !== 4'b0000) begin bad++; $display("FAIL midrst_ctrl: valid/busy/done/rd got %b want 0000", {stream_valid_o, busy_o, done_o, mem_rd_en_o}); end
    total++; if (stream_data_o !== '0 || stream_addr_o !== '0) begin bad++; $display("FAIL midrst_bus: addr %h want 0", stream_addr_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    run_job(32'h200, 16'd5, 16'd1, 0, 0, 1'b0, 40);
    build_expected(32'h200, 5, 1);
    n_err = 0;
    foreach (obs_addr[i]) if (i >= exp_q.size() || obs_addr[i] !== exp_q[i] || obs_data[i] !== mem_word(exp_q[i])) n_err++;
    total++; if (obs_addr.size() != 5 || n_err != 0 || obs_done != 1) begin bad++; $display("FAIL midrst_restart: got %0d entries (%0d wrong) done %0d want 5/0/1", obs_addr.size(), n_err, obs_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_looping();
    test_back_pressure();
    test_addr_wrap();
    test_stop_endless();
    test_zero_len();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
